// File: rtl/pcie_video_depacker_pkg.sv
// Shared constants and types for the PCIe video line depacker.
// Holds the header codes, the default line length, the FSM state set
// and a lane-compare helper.
package pcie_video_depacker_pkg;

   localparam logic [15:0] HDR_IDLE  = 16'hFFFF;
   localparam logic [15:0] HDR_FRAME = 16'hA55A;
   localparam logic [15:0] HDR_LINE  = 16'hC33C;

   localparam int DEF_PAYLOAD_BEATS = 160;
   localparam int LANES             = 8;

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_SKIP    = 2'd2
   } state_t;

   // A header code counts only when all eight lanes carry it.
   function automatic logic all_lanes(
      input logic [127:0] d,
      input logic [15:0]  p
   );
      return d == {LANES{p}};
   endfunction

endpackage

// File: rtl/pcie_beat_serializer.sv
// 128-bit beat register serialised into eight 16-bit pixels, lane 0 first.
// Ports: clk/rst, i_load/i_data/i_sof/i_eol (beat load with line flags),
// o_can_load, o_pix_valid/i_pix_ready/o_pix_data/o_pix_sof/o_pix_eol.
module pcie_beat_serializer
   import pcie_video_depacker_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [127:0] i_data,
   input  logic         i_sof,
   input  logic         i_eol,
   output logic         o_can_load,
   output logic         o_pix_valid,
   input  logic         i_pix_ready,
   output logic [15:0]  o_pix_data,
   output logic         o_pix_sof,
   output logic         o_pix_eol
);

   logic [127:0] r_data;
   logic         r_full;
   logic [2:0]   r_lane;
   logic         r_sof;
   logic         r_eol;

   logic w_acc;
   logic w_last;

   assign w_acc  = r_full && i_pix_ready;
   assign w_last = w_acc && (r_lane == 3'(LANES - 1));

   // Reloading while lane 7 leaves keeps pixels back to back.
   assign o_can_load = !r_full || w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_full <= 1'b0;
         r_lane <= '0;
         r_sof  <= 1'b0;
         r_eol  <= 1'b0;
      end else if (i_load) begin
         r_data <= i_data;
         r_full <= 1'b1;
         r_lane <= '0;
         r_sof  <= i_sof;
         r_eol  <= i_eol;
      end else if (w_acc) begin
         r_lane <= r_lane + 3'd1;
         if (w_last) r_full <= 1'b0;
      end
   end

   assign o_pix_valid = r_full;
   assign o_pix_data  = r_data[{r_lane, 4'b0000} +: 16];
   assign o_pix_sof   = r_full && r_sof && (r_lane == 3'd0);
   assign o_pix_eol   = r_full && r_eol && (r_lane == 3'(LANES - 1));

endmodule

// File: rtl/pcie_video_depacker.sv
// Line depacker: header classification FSM, beat/line counters and
// a beat serialiser. Ports: clk, rst, in_valid/in_ready/in_data,
// pix_valid/pix_ready/pix_data/pix_sof/pix_eol, line_cnt, hdr_err.
module pcie_video_depacker
   import pcie_video_depacker_pkg::*;
#(
   parameter int PAYLOAD_BEATS = DEF_PAYLOAD_BEATS,
   parameter int LINE_W        = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [15:0]       pix_data,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic [LINE_W-1:0] line_cnt,
   output logic              hdr_err
);

   localparam int BW = (PAYLOAD_BEATS > 1) ? $clog2(PAYLOAD_BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(PAYLOAD_BEATS - 1);

   state_t r_state;
   state_t w_next;

   logic [BW-1:0]     r_beat;
   logic              r_drain;
   logic              r_frame;
   logic              r_hdr_err;
   logic [LINE_W-1:0] r_line;

   logic w_ready;
   logic w_xfer;
   logic w_hdr_acc;
   logic w_load;
   logic w_skip_acc;
   logic w_can_load;
   logic w_eol_acc;
   logic w_is_frame;
   logic w_is_line;
   logic w_is_idle;
   logic w_beat_last;

   assign w_is_frame  = all_lanes(in_data, HDR_FRAME);
   assign w_is_line   = all_lanes(in_data, HDR_LINE);
   assign w_is_idle   = all_lanes(in_data, HDR_IDLE);
   assign w_beat_last = (r_beat == LAST_BEAT);

   assign w_xfer     = in_valid && w_ready;
   assign w_hdr_acc  = w_xfer && (r_state == ST_HDR);
   assign w_load     = w_xfer && (r_state == ST_PAYLOAD);
   assign w_skip_acc = w_xfer && (r_state == ST_SKIP);
   assign w_eol_acc  = pix_valid && pix_ready && pix_eol;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_HDR;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_HDR: begin
            if (w_hdr_acc)
               w_next = (w_is_frame || w_is_line) ? ST_PAYLOAD : ST_SKIP;
         end
         ST_PAYLOAD: begin
            if (w_eol_acc) w_next = ST_HDR;
         end
         ST_SKIP: begin
            if (w_skip_acc && w_beat_last) w_next = ST_HDR;
         end
         default: w_next = ST_HDR;
      endcase
   end

   // Once the last beat is loaded, input stays closed until it drains.
   always_comb begin
      w_ready = 1'b0;
      unique case (r_state)
         ST_HDR:     w_ready = 1'b1;
         ST_SKIP:    w_ready = 1'b1;
         ST_PAYLOAD: w_ready = !r_drain && w_can_load;
         default:    w_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat    <= '0;
         r_drain   <= 1'b0;
         r_frame   <= 1'b0;
         r_hdr_err <= 1'b0;
         r_line    <= '0;
      end else begin
         r_hdr_err <= w_hdr_acc &&
                      !(w_is_frame || w_is_line || w_is_idle);
         if (w_hdr_acc) begin
            r_beat  <= '0;
            r_drain <= 1'b0;
            r_frame <= w_is_frame;
            if (w_is_frame)
               r_line <= LINE_W'(1);
            else if (w_is_line && !(&r_line))
               r_line <= r_line + LINE_W'(1);
         end
         if (w_load || w_skip_acc)
            r_beat <= w_beat_last ? '0 : r_beat + BW'(1);
         if (w_load && w_beat_last)
            r_drain <= 1'b1;
      end
   end

   pcie_beat_serializer u_ser (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_data      (in_data),
      .i_sof       (r_frame && (r_beat == '0)),
      .i_eol       (w_beat_last),
      .o_can_load  (w_can_load),
      .o_pix_valid (pix_valid),
      .i_pix_ready (pix_ready),
      .o_pix_data  (pix_data),
      .o_pix_sof   (pix_sof),
      .o_pix_eol   (pix_eol)
   );

   assign in_ready = w_ready;
   assign line_cnt = r_line;
   assign hdr_err  = r_hdr_err;

endmodule

// File: tb/tb_pcie_video_depacker.sv
// Self-checking bench for pcie_video_depacker with a queue-based pixel
// model; a second PAYLOAD_BEATS=1 instance exercises line_cnt saturation.
module tb_pcie_video_depacker;
   import pcie_video_depacker_pkg::*;

   localparam int PB   = 160;
   localparam int LW   = 11;
   localparam int NPIX = PB * 8;
   localparam int LMAX = 2047;
   localparam int TP   = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  in_data;
   logic          pix_valid;
   logic          pix_ready;
   logic [15:0]   pix_data;
   logic          pix_sof;
   logic          pix_eol;
   logic [LW-1:0] line_cnt;
   logic          hdr_err;

   logic          in_valid2;
   logic          in_ready2;
   logic [127:0]  in_data2;
   logic          pix_valid2;
   logic          pix_ready2;
   logic [15:0]   pix_data2;
   logic          pix_sof2;
   logic          pix_eol2;
   logic [LW-1:0] line_cnt2;
   logic          hdr_err2;

   always #(TP/2) clk = ~clk;

   pcie_video_depacker #(.PAYLOAD_BEATS(PB), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .line_cnt(line_cnt), .hdr_err(hdr_err)
   );

   pcie_video_depacker #(.PAYLOAD_BEATS(1), .LINE_W(LW)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .pix_valid(pix_valid2), .pix_ready(pix_ready2),
      .pix_data(pix_data2), .pix_sof(pix_sof2), .pix_eol(pix_eol2),
      .line_cnt(line_cnt2), .hdr_err(hdr_err2)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        sof;
      logic        eol;
   } pix_t;

   pix_t  exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    exp_lc   = 0;
   int    pix_cnt  = 0;
   int    err_cyc  = 0;
   int    sof_cnt  = 0;
   int    in_line  = 0;
   bit    ignore   = 1'b0;
   bit    rdy_rand = 1'b0;
   bit    held     = 1'b0;
   logic [17:0] saved;
   logic [15:0] first_pix;
   pix_t  e_mon;
   time   first_t, last_t, acc_t, b0_t;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         pix_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst || ignore) begin
         held = 1'b0;
      end else begin
         if (hdr_err) err_cyc++;
         if (held) begin
            check("hold_valid", {31'd0, pix_valid}, 32'd1);
            check("hold_data", {14'd0, pix_data, pix_sof, pix_eol},
                  {14'd0, saved});
         end
         held  = pix_valid && !pix_ready;
         saved = {pix_data, pix_sof, pix_eol};
         if (pix_valid && pix_ready) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
               check("extra_pix", 32'd1, 32'd0);
            end else begin
               e_mon = exp_q.pop_front();
               check("pixel", {14'd0, pix_data, pix_sof, pix_eol},
                     {14'd0, e_mon});
            end
            if (in_line == 0) first_pix = pix_data;
            in_line = pix_eol ? 0 : in_line + 1;
            if (pix_sof) begin
               sof_cnt++;
               first_t = $time;
            end
            if (pix_eol) last_t = $time;
         end
      end
   end

   task automatic put_beat(input logic [127:0] d, input int gap);
      int t;
      bit acc;
      in_valid = 1'b0;
      if (gap > 0)
         repeat ($urandom_range(0, gap)) begin
            @(posedge clk);
            #1;
         end
      in_valid = 1'b1;
      in_data  = d;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 20000) begin
         @(negedge clk);
         acc   = in_ready;
         acc_t = $time;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      if (!acc) check("in_timeout", 32'd0, 32'd1);
   endtask

   task automatic put_beat2(input logic [127:0] d);
      int t;
      bit acc;
      in_valid2 = 1'b1;
      in_data2  = d;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = in_ready2;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid2 = 1'b0;
      if (!acc) check("in2_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_line(input logic [127:0] hdr, input bit rnd,
                            input int gap, input int nb, input bit track);
      logic [127:0] b;
      logic [15:0]  n16;
      pix_t e;
      bit frame, line;
      frame = (hdr == {8{HDR_FRAME}});
      line  = (hdr == {8{HDR_LINE}});
      if (track) begin
         if (frame) exp_lc = 1;
         else if (line && exp_lc < LMAX) exp_lc++;
      end
      put_beat(hdr, gap);
      for (int n = 0; n < nb; n++) begin
         n16 = n[15:0];
         b = rnd ? {$urandom(), $urandom(), $urandom(), $urandom()}
                 : {8{n16}};
         if (track && (frame || line))
            for (int l = 0; l < 8; l++) begin
               e.d   = b[l*16 +: 16];
               e.sof = frame && (n == 0) && (l == 0);
               e.eol = (n == PB - 1) && (l == 7);
               exp_q.push_back(e);
            end
         put_beat(b, gap);
         if (n == 0) b0_t = acc_t;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 50000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain", exp_q.size(), 32'd0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #(TP * 1000000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int  p0, e0, s0, exp2;
      time t0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_valid2 = 1'b0;
      in_data2  = '0;
      pix_ready2 = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      check("rst_sof_eol", {30'd0, pix_sof, pix_eol}, 32'd0);
      check("rst_hdr_err", {31'd0, hdr_err}, 32'd0);
      check("rst_line_cnt", {21'd0, line_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rel_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Frame-start line with counting pattern, sink always ready.
      send_line({8{HDR_FRAME}}, 1'b0, 0, PB, 1'b1);
      wait_drain();
      check("t1_line_cnt", {21'd0, line_cnt}, exp_lc);
      check("t1_sof_cnt", sof_cnt, 32'd1);
      check("t1_no_bubble", 32'((last_t - first_t) / TP), NPIX - 1);
      check("t1_latency", 32'((first_t - b0_t) / TP), 32'd1);

      // Idle line yields nothing; following line starts at pixel 0x0000.
      p0 = pix_cnt;
      send_line({8{HDR_IDLE}}, 1'b0, 0, PB, 1'b1);
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      check("t2_idle_nopix", pix_cnt - p0, 32'd0);
      send_line({8{HDR_LINE}}, 1'b0, 0, PB, 1'b1);
      wait_drain();
      check("t2_first_pix", {16'd0, first_pix}, 32'd0);
      check("t2_line_cnt", {21'd0, line_cnt}, exp_lc);

      // Unrecognised header: one error pulse, full-rate discard.
      e0 = err_cyc;
      p0 = pix_cnt;
      t0 = $time;
      send_line({8{16'h1234}}, 1'b0, 0, PB, 1'b1);
      check("t3_skip_rate", 32'(($time - t0) / TP), PB + 1);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("t3_hdr_err", err_cyc - e0, 32'd1);
      check("t3_nopix", pix_cnt - p0, 32'd0);
      send_line({8{HDR_LINE}}, 1'b1, 0, PB, 1'b1);
      wait_drain();
      check("t3_line_cnt", {21'd0, line_cnt}, exp_lc);

      // Random backpressure and input gaps across two lines.
      rdy_rand = 1'b1;
      s0 = sof_cnt;
      send_line({8{HDR_FRAME}}, 1'b1, 3, PB, 1'b1);
      send_line({8{HDR_LINE}}, 1'b1, 3, PB, 1'b1);
      wait_drain();
      rdy_rand = 1'b0;
      check("t4_line_cnt", {21'd0, line_cnt}, exp_lc);
      check("t4_sof_cnt", sof_cnt - s0, 32'd1);

      // Reset in the middle of a line, then a clean frame-start line.
      ignore = 1'b1;
      send_line({8{HDR_FRAME}}, 1'b0, 0, 37, 1'b0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      exp_q.delete();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("t5_rst_valid", {31'd0, pix_valid}, 32'd0);
      check("t5_rst_line_cnt", {21'd0, line_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      ignore = 1'b0;
      in_line = 0;
      exp_lc = 0;
      s0     = sof_cnt;
      @(negedge clk);
      check("t5_rel_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      send_line({8{HDR_FRAME}}, 1'b0, 0, PB, 1'b1);
      wait_drain();
      check("t5_line_cnt", {21'd0, line_cnt}, exp_lc);
      check("t5_sof_cnt", sof_cnt - s0, 32'd1);

      // Saturation on the single-beat instance.
      for (int k = 1; k <= 2100; k++) begin
         put_beat2({8{HDR_LINE}});
         put_beat2({$urandom(), $urandom(), $urandom(), $urandom()});
         exp2 = (k > LMAX) ? LMAX : k;
         if (k == 1 || k == 2046 || k == 2047 || k == 2100)
            check("t6_sat_line_cnt", {21'd0, line_cnt2}, exp2);
      end

      check("hdr_err_total", err_cyc, 32'd1);
      check("q_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
